// File: rtl/clock_rtc_param.sv
// clock_rtc_param
//   BCD time-of-day counter (hh:mm:ss) with a built-in prescaler, a
//   selectable 12/24-hour mode, validated field writes, run/pause control
//   and an hh:mm alarm.
//
//   Parameters
//     TICK_DIV  clk cycles per second (>= 2)
//     HOUR24    1: hours 00..23, 0: hours 01..12 with pm flag
//
//   Ports
//     clk, reset      system clock, synchronous active-high reset
//     run             1: prescaler and time advance, 0: frozen
//     set_en/set_sel  one-cycle write strobe, field select (1 sec, 2 min, 3 hr, 0 none)
//     set_val/set_pm  packed BCD value, pm flag for hour writes (12h only)
//     alarm_wr        strobe latching alarm_hm / alarm_pm / alarm_on
//     time_bcd        {hr1,hr0,min1,min0,sec1,sec0}
//     pm              afternoon flag (always 0 in 24h mode)
//     sec_pulse, day_pulse, alarm_hit, set_err   one-cycle registered pulses
//
//   Control handshake: there is no back-pressure. set_en and alarm_wr are
//   single-cycle strobes sampled on every rising edge; a strobe is consumed
//   on the edge where it is high and has no effect after that.
module clock_rtc_param #(
  parameter int TICK_DIV = 50_000_000,
  parameter bit HOUR24   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        set_en,
  input  logic [1:0]  set_sel,
  input  logic [7:0]  set_val,
  input  logic        set_pm,
  input  logic        alarm_wr,
  input  logic [15:0] alarm_hm,
  input  logic        alarm_pm,
  input  logic        alarm_on,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_pulse,
  output logic        day_pulse,
  output logic        alarm_hit,
  output logic        set_err
);

  localparam int              PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   P_MAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]      HR_RST = HOUR24 ? 8'h00 : 8'h12;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic          pm_q, pm_d;
  logic [15:0]   al_hm_q, al_hm_d;
  logic          al_pm_q, al_pm_d, al_on_q, al_on_d;
  logic          sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;
  logic          alarm_hit_q, alarm_hit_d, set_err_q, set_err_d;

  // BCD +1 on a two-digit value; range wrap is handled by the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_bin(input logic [7:0] v);
    return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
  endfunction

  logic       tick, nib_ok, val_ok, set_hit;
  logic [7:0] val_bin;
  logic [7:0] sec_n, min_n, hr_n;
  logic       pm_n, day_n;

  always_comb begin
    tick    = run && (presc_q == P_MAX);
    val_bin = bcd_bin(set_val);
    nib_ok  = (set_val[7:4] <= 4'd9) && (set_val[3:0] <= 4'd9);
    case (set_sel)
      2'd1, 2'd2: val_ok = nib_ok && (val_bin <= 8'd59);
      2'd3:       val_ok = nib_ok && (HOUR24 ? (val_bin <= 8'd23)
                                             : (val_bin >= 8'd1 && val_bin <= 8'd12));
      default:    val_ok = 1'b0;
    endcase
    set_hit = set_en && (set_sel != 2'd0);

    // Candidate time after one second, with the full carry chain.
    sec_n = (sec_q == 8'h59) ? 8'h00 : bcd_inc(sec_q);
    min_n = min_q;
    hr_n  = hr_q;
    pm_n  = pm_q;
    day_n = 1'b0;
    if (sec_q == 8'h59) begin
      min_n = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
      if (min_q == 8'h59) begin
        if (HOUR24) begin
          if (hr_q == 8'h23) begin
            hr_n  = 8'h00;
            day_n = 1'b1;
          end else begin
            hr_n = bcd_inc(hr_q);
          end
        end else begin
          if (hr_q == 8'h12) begin
            hr_n = 8'h01;
          end else if (hr_q == 8'h11) begin
            // 11 -> 12 flips am/pm; going from pm to am is the new day.
            hr_n  = 8'h12;
            pm_n  = ~pm_q;
            day_n = pm_q;
          end else begin
            hr_n = bcd_inc(hr_q);
          end
        end
      end
    end

    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    alarm_hit_d = 1'b0;
    set_err_d   = set_hit && !val_ok;

    if (set_hit && val_ok) begin
      // A valid write wins over a coincident tick and restarts the second.
      presc_d = '0;
      case (set_sel)
        2'd1:    sec_d = set_val;
        2'd2:    min_d = set_val;
        default: begin
          hr_d = set_val;
          pm_d = HOUR24 ? 1'b0 : set_pm;
        end
      endcase
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        sec_d       = sec_n;
        min_d       = min_n;
        hr_d        = hr_n;
        pm_d        = pm_n;
        sec_pulse_d = 1'b1;
        day_pulse_d = day_n;
        // Compares against the alarm registers as they stand before this edge.
        alarm_hit_d = al_on_q && (sec_n == 8'h00) && ({hr_n, min_n} == al_hm_q) &&
                      (HOUR24 || (pm_n == al_pm_q));
      end
    end

    al_hm_d = alarm_wr ? alarm_hm : al_hm_q;
    al_pm_d = alarm_wr ? alarm_pm : al_pm_q;
    al_on_d = alarm_wr ? alarm_on : al_on_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hr_q        <= HR_RST;
      pm_q        <= 1'b0;
      al_hm_q     <= 16'h0000;
      al_pm_q     <= 1'b0;
      al_on_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      alarm_hit_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      pm_q        <= pm_d;
      al_hm_q     <= al_hm_d;
      al_pm_q     <= al_pm_d;
      al_on_q     <= al_on_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      alarm_hit_q <= alarm_hit_d;
      set_err_q   <= set_err_d;
    end
  end

  assign time_bcd  = {hr_q, min_q, sec_q};
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;
  assign alarm_hit = alarm_hit_q;
  assign set_err   = set_err_q;

endmodule
